// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle for the two-entry skid pipeline stage.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] in_pc4;
  logic [REG_W-1:0]  in_wreg;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_wdata;
  logic [DATA_W-1:0] out_pc4;
  logic [REG_W-1:0]  out_wreg;
  logic [CNT_W-1:0]  stall_cnt;

  // Upstream/downstream environment side.
  modport master (
    output flush, in_valid, in_ctrl, in_alu, in_wdata, in_pc4, in_wreg, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu, out_wdata, out_pc4, out_wreg, stall_cnt
  );

  // Pipeline stage side.
  modport slave (
    input  flush, in_valid, in_ctrl, in_alu, in_wdata, in_pc4, in_wreg, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu, out_wdata, out_pc4, out_wreg, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline register stage with flush, bubble ctrl
// masking and a saturating backpressure counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               clr,
  pipe_stage_skid_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc4;
    logic [REG_W-1:0]  wreg;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept;
  logic             xfer;

  assign in_entry = {bus.in_ctrl, bus.in_alu, bus.in_wdata, bus.in_pc4, bus.in_wreg};

  // Handshake decoded purely from state: no out_ready -> in_ready path.
  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign xfer          = bus.out_valid && bus.out_ready;

  // Next state, entry moves and stall counting.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    if (bus.flush) begin
      // Squash kills ctrl only; payload bits are left as they were.
      state_d     = EMPTY;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
        stall_d = stall_q + CNT_W'(1);
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // A bubble must never present reg_write/mem_write.
  assign bus.out_ctrl  = bus.out_valid ? main_q.ctrl : '0;
  assign bus.out_alu   = main_q.alu;
  assign bus.out_wdata = main_q.wdata;
  assign bus.out_pc4   = main_q.pc4;
  assign bus.out_wreg  = main_q.wreg;
  assign bus.stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each data field (ALU result, store data, PC+4).
REQ-002 SHALL have parameter REG_W, default 5: destination register index width.
REQ-003 SHALL have parameter CTRL_W, default 3: control field width; bit0 reg_write, bit1 mem_to_reg, bit2 mem_write.
REQ-004 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-005 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge; reset clr, asynchronous, active-high; clock clk.
- clr  in  1  asynchronous active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_alu  in  DATA_W  upstream ALU result.
- in_wdata  in  DATA_W  upstream store data.
- in_pc4  in  DATA_W  upstream PC+4.
- in_wreg  in  REG_W  upstream destination register.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  held control bits.
- out_alu  out  DATA_W  held ALU result.
- out_wdata  out  DATA_W  held store data.
- out_pc4  out  DATA_W  held PC+4.
- out_wreg  out  REG_W  held destination register.
- stall_cnt  out  CNT_W  saturating count of backpressured cycles.

Function
REQ-006 SHALL hold two entries: main (drives out_*) and skid; state EMPTY (none), ONE (main valid), TWO (main and skid valid).
REQ-007 SHALL decode in_ready = 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-008 SHALL accept on a rising edge when in_valid && in_ready, and SHALL complete a transfer on a rising edge when out_valid && out_ready.
REQ-009 SHALL drive out_valid = 1 exactly in ONE and TWO.
REQ-010 SHALL use these transitions: EMPTY+accept -> ONE (data into main). ONE+accept+transfer -> ONE (new data into main). ONE+accept, no transfer -> TWO (data into skid). ONE+transfer, no accept -> EMPTY. TWO+transfer -> ONE (skid moves to main). All other cases hold state.
REQ-011 SHALL preserve strict FIFO order, with latency of 1 cycle from accept to out_valid when the stage is empty.
REQ-012 SHALL update no field while the state holds; outputs are stable while out_valid && !out_ready.
REQ-013 SHALL, on flush at a rising edge, go to EMPTY, zero main and skid ctrl fields, and retain data fields. Flush SHALL override a simultaneous accept, which is dropped, and a simultaneous transfer.
REQ-014 SHALL force out_ctrl to all-zero whenever out_valid = 0, so a bubble never asserts reg_write or mem_write.
REQ-015 SHALL increment stall_cnt on each rising edge with out_valid && !out_ready, saturate at 2^CNT_W-1, and not count during a flush cycle.
REQ-016 SHALL pass all fields unmodified; no arithmetic on payload.

Reset
REQ-017 SHALL, while clr = 1, force state EMPTY, in_ready = 1, out_valid = 0, all out_* fields = 0, stall_cnt = 0, independent of clk.
REQ-018 SHALL discard any held entries when clr is asserted mid-operation; the first accept after clr deasserts appears at out_* one cycle later.

Verification
REQ-019 SHALL pass a streaming scenario: out_ready = 1, accept in_alu = 0x10, 0x20, 0x30 on consecutive cycles -> out_alu shows 0x10, 0x20, 0x30 on consecutive cycles, and in_ready stays 1.
REQ-020 SHALL pass a backpressure scenario: out_ready = 0, offer 0xA then 0xB -> state TWO and in_ready = 0. Then raise out_ready -> 0xA then 0xB emerge in order, with no loss or duplication.
REQ-021 SHALL pass a flush scenario: state TWO with in_ctrl = 3'b101, pulse flush with in_valid = 1 -> next cycle out_valid = 0, out_ctrl = 0, the offered entry is dropped, and in_ready = 1.
REQ-022 SHALL pass a stall-counter scenario: hold out_valid = 1 and out_ready = 0 for 5 cycles -> stall_cnt = 5. With CNT_W = 2 and 6 cycles -> stall_cnt = 3.
REQ-023 SHALL pass an asynchronous-reset scenario: assert clr between clock edges while in TWO -> out_valid = 0, out_alu = 0, and in_ready = 1 immediately, before the next edge.
REQ-024 SHALL pass a parameter scenario: instantiate with DATA_W = 64, REG_W = 6, CTRL_W = 4, and rerun REQ-019/020 with the value 0xFFFF_0000_1234_5678 -> the value is passed through intact.
